lsu_axi_master: RTL and testbench
=================================

Name: lsu_axi_master

Overview:
Stand-alone, parametrised load/store unit. It accepts one memory request at a time from the execute stage through a valid/ready handshake. It performs a single-beat AXI4 read or write, including byte-lane alignment, strobe generation and load sign/zero extension. It returns data and an error code through a second valid/ready handshake to writeback. It replaces the inline AXI logic in the execute stage, and adds misalignment trapping, bus-error reporting, 64-bit support and proper AW/W independence.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus/data width; 32 or 64 only
ID, 0, constant value driven on awid/arid

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  unit idle, can accept
req_wr  in  1  1 = store, 0 = load
req_op  in  3  000 b, 001 h, 010 w, 011 d (DATA_W=64 only), 100 bu, 101 hu, 110 wu (DATA_W=64 only)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  response valid
resp_ready  in  1  consumer ready
resp_rdata  out  DATA_W  extended load data; 0 for stores or on error
resp_err  out  2  00 ok, 01 misaligned, 10 bus error (resp != OKAY), 11 illegal op
awvalid/awready/awaddr/awid(4)/awlen(8)/awsize(3)/awburst(2)  AXI4 AW channel
wvalid/wready/wdata(DATA_W)/wstrb(DATA_W/8)/wlast  AXI4 W channel
bvalid/bready/bresp(2)/bid(4)  AXI4 B channel
arvalid/arready/araddr/arid(4)/arlen(8)/arsize(3)/arburst(2)  AXI4 AR channel
rvalid/rready/rdata(DATA_W)/rresp(2)/rlast/rid(4)  AXI4 R channel

Behaviour:
- FSM states: IDLE, RD_A, RD_D, WR_AW (AW/W in flight), WR_B, RESP. On reset: state IDLE; every valid/ready output 0 except req_ready=1; resp_rdata=0; resp_err=0.
- req_ready = (state==IDLE). On accept (req_valid & req_ready), latch wr, op, addr and wdata.
- Accept-time checks, evaluated in priority order:
  - Illegal op → RESP next cycle with err=11.
  - Misaligned → RESP next cycle with err=01. Misaligned means h with addr[0]≠0, w with addr[1:0]≠0, or d with addr[2:0]≠0. No bus activity occurs in either error case.
- Load path: IDLE → RD_A.
  - arvalid=1 starting the cycle after accept; held stable until arready.
  - araddr = latched addr; arsize = op[1:0]; arlen=0; arburst=01 (INCR).
  - On the AR handshake → RD_D, with rready=1.
  - On the R handshake: capture rdata; err=10 if rresp≠00; → RESP next cycle.
  - rlast is not checked; rid is ignored.
- Store path: IDLE → WR_AW.
  - awvalid and wvalid both rise the cycle after accept and drop independently on their own handshakes. Either order, or the same cycle, is legal.
  - When both handshakes are done → WR_B, with bready=1 only in this state.
  - On the B handshake: err=10 if bresp≠00; → RESP.
  - wlast = wvalid (single beat).
- Lane handling: off = addr[log2(DATA_W/8)-1:0]. Base mask is b:1, h:3, w:F, d:FF.
  - wdata = req_wdata << (off*8).
  - wstrb = base mask << off.
  - Load: rdata >> (off*8), then sign-extended (ops 0xx) or zero-extended (ops 1xx) from the access size to DATA_W.
  - When DATA_W=32, "w" needs no extension.
- RESP: resp_valid=1, with rdata/err held stable until resp_ready. On the handshake → IDLE, and req_ready becomes 1 the following cycle. There is no same-cycle response→accept bypass.
- Latency with zero-wait slave: load accept → resp_valid = 3 cycles; store = 3 cycles.
- Async reset mid-transaction: immediate return to the reset values. The in-flight AXI transaction is abandoned; the interconnect is reset by the same signal.
- req_* inputs are ignored outside IDLE. bvalid/rvalid arriving in an unexpected state are ignored; ready stays 0.

Decomposition:
- Shared package lsu_pkg holds:
  - op encodings (LSU_B … LSU_WU)
  - err codes
  - AXI constants (BURST_INCR, RESP_OKAY)
  - FSM state enum
- One sub-module, lsu_lane_align (combinational): produces wdata/wstrb from the store side and extended data from the load side. Parametrised by DATA_W.

Test Plan:
- DATA_W=32, lw addr 0x80000100, slave returns rdata 0xDEADBEEF after 2 wait cycles → araddr 0x80000100, arsize 010, resp_rdata 0xDEADBEEF, err 00.
- lb addr 0x80000003, rdata 0x80FFFFFF → resp_rdata 0xFFFFFF80; lbu at the same address → 0x00000080.
- sh addr 0x80000002, req_wdata 0x0000ABCD → wdata 0xABCD0000, wstrb 1100, awsize 001. With wready asserted 3 cycles before awready, both channels complete correctly and bready rises only after both.
- lw addr 0x80000002 → err 01 one cycle after accept; arvalid/awvalid never asserted.
- sw with bresp=10 → err 10. lw with rresp=11 → err 10, rdata 0.
- resp_ready held low for 5 cycles → resp_valid/data stable, req_ready stays 0. Assert rst during RD_D → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, error codes, AXI constants and FSM states.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

  // Doubleword and unsigned-word accesses only exist on a 64-bit bus.
  function automatic logic op_legal(input logic [2:0] op, input logic is64);
    case (op)
      LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: op_legal = 1'b1;
      LSU_D, LSU_WU:                       op_legal = is64;
      default:                             op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] lo);
    case (op[1:0])
      2'b01:   is_misaligned = lo[0] != 1'b0;
      2'b10:   is_misaligned = lo[1:0] != 2'b00;
      2'b11:   is_misaligned = lo != 3'b000;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_axi_if.sv
// Single AXI4 master port as used by the load/store unit (all five channels).
interface lsu_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic       bvalid, bready;
  logic [1:0] bresp;
  logic [3:0] bid;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid, arready,
    input  rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid, arready,
    output rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data/strobe shifted to the addressed lane, load data shifted down and extended.
// Purely combinational, no latency, no flow control.
module lsu_lane_align #(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [2:0]        op,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] ld_ext
);

  logic [7:0]        base;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext_w;

  assign sh    = ld_data >> {off, 3'b000};
  assign wdata = st_data << {off, 3'b000};
  assign wstrb = STRB_W'(base) << off;

  // A word already fills a 32-bit bus, so extension only exists for the 64-bit build.
  if (DATA_W > 32) begin : g_w_ext
    assign ext_w = op[2] ? {{(DATA_W-32){1'b0}}, sh[31:0]}
                         : {{(DATA_W-32){sh[31]}}, sh[31:0]};
  end else begin : g_w_noext
    assign ext_w = sh;
  end

  always_comb begin
    base   = 8'hFF;
    ld_ext = sh;
    case (op[1:0])
      2'b00: begin
        base   = 8'h01;
        ld_ext = op[2] ? {{(DATA_W-8){1'b0}}, sh[7:0]} : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        base   = 8'h03;
        ld_ext = op[2] ? {{(DATA_W-16){1'b0}}, sh[15:0]} : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      end
      2'b10: begin
        base   = 8'h0F;
        ld_ext = ext_w;
      end
      default: begin
        base   = 8'hFF;
        ld_ext = sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// One-at-a-time load/store unit issuing single-beat AXI4 reads/writes, with misalign/illegal trapping.
// Latency 3 cycles accept->resp_valid on a zero-wait slave; holds the response until resp_ready.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  lsu_axi_if.master         axi
);

  localparam int         OFF_W  = $clog2(DATA_W / 8);
  localparam logic [3:0] AXI_ID = 4'(ID);
  localparam logic       IS64   = (DATA_W == 64);

  lsu_state_t        st, st_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ld_ext;
  logic [1:0]        err_q;
  logic              aw_done, w_done;
  logic              req_bad;
  logic [1:0]        req_err;
  logic              unused_ok;

  assign unused_ok = ^{axi.rlast, axi.rid, axi.bid};

  always_comb begin
    req_err = ERR_OK;
    if (!op_legal(req_op, IS64))                req_err = ERR_ILLEGAL;
    else if (is_misaligned(req_op, req_addr[2:0])) req_err = ERR_MISALIGN;
  end
  assign req_bad = (req_err != ERR_OK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt      = st;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (st)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)     st_nxt = RESP;
          else if (req_wr) st_nxt = WR_AW;
          else             st_nxt = RD_A;
        end
      end
      RD_A: begin
        axi.arvalid = 1'b1;
        if (axi.arready) st_nxt = RD_D;
      end
      RD_D: begin
        axi.rready = 1'b1;
        if (axi.rvalid) st_nxt = RESP;
      end
      WR_AW: begin
        // AW and W retire independently; leave once both have handshaken.
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
        if ((aw_done || axi.awready) && (w_done || axi.wready)) st_nxt = WR_B;
      end
      WR_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) st_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (st == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (st == WR_AW) begin
        if (axi.awvalid && axi.awready) aw_done <= 1'b1;
        if (axi.wvalid && axi.wready)   w_done  <= 1'b1;
      end
      if (st == RD_D && axi.rvalid) begin
        if (axi.rresp != RESP_OKAY) err_q   <= ERR_BUS;
        else                        rdata_q <= ld_ext;
      end
      if (st == WR_B && axi.bvalid && axi.bresp != RESP_OKAY) err_q <= ERR_BUS;
    end
  end

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op      (op_q),
    .off     (addr_q[OFF_W-1:0]),
    .st_data (wdata_q),
    .ld_data (axi.rdata),
    .wdata   (axi.wdata),
    .wstrb   (axi.wstrb),
    .ld_ext  (ld_ext)
  );

  assign axi.awaddr  = addr_q;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = {1'b0, op_q[1:0]};
  assign axi.awburst = BURST_INCR;
  assign axi.wlast   = axi.wvalid;
  assign axi.araddr  = addr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, op_q[1:0]};
  assign axi.arburst = BURST_INCR;

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master (32-bit build) with a hand-driven AXI slave.
module tb_lsu_axi_master;
  import lsu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_wr;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [1:0]    resp_err;

  lsu_axi_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  lsu_axi_master #(.ADDR_W(AW), .DATA_W(DW), .ID(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Addresses/data seen on the bus during the last transaction.
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [2:0]  ar_size, aw_size;
  logic [7:0]  ar_len;
  logic [1:0]  ar_burst;
  logic [3:0]  w_strb;
  logic        w_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
    req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
    acc_cyc = cyc;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_op = 3'b111; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_resp(output int lat);
    int n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("resp_timeout", resp_valid, 1);
    lat = cyc - acc_cyc;
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                         input logic [1:0] rr, input int rwait, input int hold,
                         output logic [31:0] d, output logic [1:0] e, output int lat);
    int n = 0;
    accept(1'b0, op, addr, '0);
    while (!axi.arvalid && n < 20) begin @(negedge clk); n++; end
    chk("arvalid", axi.arvalid, 1);
    ar_addr = axi.araddr; ar_size = axi.arsize; ar_len = axi.arlen; ar_burst = axi.arburst;
    axi.arready = 1'b1;
    @(posedge clk); @(negedge clk);
    axi.arready = 1'b0;
    chk("ar_drop", axi.arvalid, 0);
    repeat (rwait) @(negedge clk);
    chk("rready", axi.rready, 1);
    axi.rvalid = 1'b1; axi.rdata = rd; axi.rresp = rr;
    @(posedge clk); @(negedge clk);
    axi.rvalid = 1'b0; axi.rdata = 32'hBAD0BAD0; axi.rresp = 2'b00;
    wait_resp(lat);
    d = resp_rdata; e = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_op = LSU_B; req_addr = 32'h0;
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", {resp_rdata, 30'd0, resp_err}, {d, 30'd0, e});
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    take_resp();
  endtask

  task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int aw_dly, input int w_dly, input logic [1:0] br,
                          output logic [31:0] d, output logic [1:0] e, output int lat);
    int n = 0, early = 0, bad_valid = 0;
    logic aw_ok = 1'b0, w_ok = 1'b0, aw_now, w_now;
    accept(1'b1, op, addr, wd);
    while (!(aw_ok && w_ok) && n < 20) begin
      axi.awready = (n >= aw_dly);
      axi.wready  = (n >= w_dly);
      if (axi.bready) early++;
      if (aw_ok == axi.awvalid) bad_valid++;
      if (w_ok == axi.wvalid) bad_valid++;
      aw_now = axi.awvalid && axi.awready;
      w_now  = axi.wvalid && axi.wready;
      if (aw_now) begin aw_addr = axi.awaddr; aw_size = axi.awsize; end
      if (w_now) begin w_data = axi.wdata; w_strb = axi.wstrb; w_last = axi.wlast; end
      @(posedge clk); @(negedge clk);
      aw_ok = aw_ok | aw_now; w_ok = w_ok | w_now; n++;
    end
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk("aw_w_done", {aw_ok, w_ok}, 2'b11);
    chk("bready_early", early, 0);
    chk("valid_hold_drop", bad_valid, 0);
    chk("bready", axi.bready, 1);
    axi.bvalid = 1'b1; axi.bresp = br;
    @(posedge clk); @(negedge clk);
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    wait_resp(lat);
    d = resp_rdata; e = resp_err;
    take_resp();
  endtask

  logic [31:0] d;
  logic [1:0]  e;
  int          lat;

  initial begin
    req_valid = 0; req_wr = 0; req_op = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rid = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {resp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}, 0);
    chk("rst_resp", {resp_rdata, resp_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // lw with two R wait states
    do_load(LSU_W, 32'h8000_0100, 32'hDEAD_BEEF, 2'b00, 2, 0, d, e, lat);
    chk("lw_araddr", ar_addr, 32'h8000_0100);
    chk("lw_arsize", ar_size, 3'b010);
    chk("lw_arlen_burst", {ar_len, ar_burst}, {8'd0, 2'b01});
    chk("lw_data", d, 32'hDEAD_BEEF);
    chk("lw_err", e, 2'b00);
    chk("lw_lat", lat, 5);
    chk("lw_idle_after", req_ready, 1);

    do_load(LSU_B, 32'h8000_0003, 32'h80FF_FFFF, 2'b00, 0, 0, d, e, lat);
    chk("lb_data", d, 32'hFFFF_FF80);
    chk("lb_lat", lat, 3);
    chk("lb_arsize", ar_size, 3'b000);
    do_load(LSU_BU, 32'h8000_0003, 32'h80FF_FFFF, 2'b00, 0, 0, d, e, lat);
    chk("lbu_data", d, 32'h0000_0080);
    do_load(LSU_H, 32'h8000_0002, 32'h8001_1234, 2'b00, 0, 0, d, e, lat);
    chk("lh_data", d, 32'hFFFF_8001);
    do_load(LSU_HU, 32'h8000_0002, 32'h8001_1234, 2'b00, 0, 0, d, e, lat);
    chk("lhu_data", d, 32'h0000_8001);

    // sh: W accepted three cycles before AW
    do_store(LSU_H, 32'h8000_0002, 32'h0000_ABCD, 3, 0, 2'b00, d, e, lat);
    chk("sh_awaddr", aw_addr, 32'h8000_0002);
    chk("sh_awsize", aw_size, 3'b001);
    chk("sh_wdata", w_data, 32'hABCD_0000);
    chk("sh_wstrb", w_strb, 4'b1100);
    chk("sh_wlast", w_last, 1);
    chk("sh_resp", {d, e}, 34'd0);
    chk("sh_lat", lat, 6);

    do_store(LSU_W, 32'h8000_0004, 32'h1234_5678, 0, 0, 2'b00, d, e, lat);
    chk("sw_wdata", w_data, 32'h1234_5678);
    chk("sw_wstrb", w_strb, 4'b1111);
    chk("sw_awsize", aw_size, 3'b010);
    chk("sw_lat", lat, 3);

    // sb: AW first, W two cycles later
    do_store(LSU_B, 32'h8000_0001, 32'h0000_00AB, 0, 2, 2'b00, d, e, lat);
    chk("sb_wdata", w_data, 32'h0000_AB00);
    chk("sb_wstrb", w_strb, 4'b0010);
    chk("sb_lat", lat, 5);

    do_store(LSU_W, 32'h8000_0008, 32'h5555_AAAA, 0, 0, 2'b10, d, e, lat);
    chk("sw_slverr", e, 2'b10);
    do_load(LSU_W, 32'h8000_000C, 32'h1122_3344, 2'b11, 0, 0, d, e, lat);
    chk("lw_decerr", {d, e}, {32'h0, 2'b10});

    // misaligned load and store: response next cycle, no bus activity
    accept(1'b0, LSU_W, 32'h8000_0002, '0);
    chk("mis_lw", {resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid}, {1'b1, 2'b01, 3'b000});
    chk("mis_lw_lat", cyc - acc_cyc, 1);
    take_resp();
    accept(1'b1, LSU_HU, 32'h8000_0001, 32'h1);
    chk("mis_sh", {resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid}, {1'b1, 2'b01, 3'b000});
    take_resp();

    // illegal ops on a 32-bit bus win over misalignment
    accept(1'b0, LSU_D, 32'h8000_0001, '0);
    chk("ill_d", {resp_valid, resp_err, axi.arvalid}, {1'b1, 2'b11, 1'b0});
    take_resp();
    accept(1'b1, 3'b111, 32'h8000_0000, '0);
    chk("ill_111", {resp_valid, resp_err, axi.awvalid, axi.wvalid}, {1'b1, 2'b11, 2'b00});
    take_resp();

    // response backpressure for 5 cycles with a competing request
    do_load(LSU_HU, 32'h8000_0002, 32'hFEDC_0000, 2'b00, 0, 5, d, e, lat);
    chk("hold_lhu_data", d, 32'h0000_FEDC);
    chk("hold_after_idle", {req_ready, axi.arvalid}, 2'b10);

    // async reset while waiting for R
    accept(1'b0, LSU_W, 32'h8000_0200, '0);
    axi.arready = 1'b1;
    @(posedge clk); @(negedge clk);
    axi.arready = 1'b0;
    chk("rd_d_rready", axi.rready, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_valids", {resp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}, 0);
    chk("arst_resp", {resp_rdata, resp_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    axi.rvalid = 1'b1; axi.bvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ignored", {axi.rready, axi.bready, resp_valid, req_ready}, 4'b0001);
    end
    axi.rvalid = 1'b0; axi.bvalid = 1'b0;

    do_load(LSU_W, 32'h8000_0010, 32'h0BAD_F00D, 2'b00, 0, 0, d, e, lat);
    chk("post_rst_lw", {d, e}, {32'h0BAD_F00D, 2'b00});
    chk("post_rst_lat", lat, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
